// File: rtl/bsr_chain_param.sv
// Parametrised boundary-scan register: an N_IN input-cell plus N_OUT output-cell
// shift/update chain, with an instruction-mode output mux and a saturating shift counter.
module bsr_chain_param #(
  parameter int                N_IN     = 36,
  parameter int                N_OUT    = 39,
  parameter logic [N_IN-1:0]   IN_SAFE  = '0,
  parameter logic [N_OUT-1:0]  OUT_SAFE = '0,
  parameter int                CNT_W    = 16
) (
  input  logic              CK,
  input  logic              reset,
  input  logic              clockdr,
  input  logic              shiftdr,
  input  logic              updatedr,
  input  logic [1:0]        mode,
  input  logic              TDI,
  input  logic [N_IN-1:0]   pin_in,
  output logic [N_IN-1:0]   core_in,
  input  logic [N_OUT-1:0]  core_out,
  output logic [N_OUT-1:0]  pin_out,
  output logic              TDO,
  output logic [CNT_W-1:0]  shift_cnt
);

  localparam int N = N_IN + N_OUT;

  localparam logic [1:0] MODE_FUNCTIONAL = 2'b00;
  localparam logic [1:0] MODE_SAMPLE     = 2'b01;
  localparam logic [1:0] MODE_EXTEST     = 2'b10;
  localparam logic [1:0] MODE_INTEST     = 2'b11;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [N-1:0]     sh_q, sh_d;
  logic [N-1:0]     up_q, up_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next-state for shift stage, update stage and shift counter.
  always_comb begin
    sh_d  = sh_q;
    up_d  = up_q;
    cnt_d = cnt_q;
    if (clockdr) begin
      if (shiftdr) begin
        sh_d = {sh_q[N-2:0], TDI};
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          cnt_d = cnt_q;
        end
      end else begin
        sh_d  = {core_out, pin_in};
        cnt_d = '0;
      end
    end else begin
      sh_d  = sh_q;
      cnt_d = cnt_q;
    end
    // Update always samples the pre-edge shift stage, even when clockdr acts too.
    if (updatedr) begin
      up_d = sh_q;
    end else begin
      up_d = up_q;
    end
  end

  // State registers; the update stage resets to the pin-safe values.
  always_ff @(posedge CK or posedge reset) begin
    if (reset) begin
      sh_q  <= '0;
      up_q  <= {OUT_SAFE, IN_SAFE};
      cnt_q <= '0;
    end else begin
      sh_q  <= sh_d;
      up_q  <= up_d;
      cnt_q <= cnt_d;
    end
  end

  assign TDO       = sh_q[N-1];
  assign shift_cnt = cnt_q;

  // Instruction-mode mux between live functional paths and the update stage.
  always_comb begin
    core_in = pin_in;
    pin_out = core_out;
    case (mode)
      MODE_FUNCTIONAL, MODE_SAMPLE: begin
        core_in = pin_in;
        pin_out = core_out;
      end
      MODE_EXTEST: begin
        core_in = pin_in;
        pin_out = up_q[N-1:N_IN];
      end
      MODE_INTEST: begin
        core_in = up_q[N_IN-1:0];
        pin_out = core_out;
      end
      default: begin
        core_in = pin_in;
        pin_out = core_out;
      end
    endcase
  end

endmodule

// File: tb/tb_bsr_chain_param.sv
// Directed bench for bsr_chain_param with 4 input cells, 3 output cells and a
// 3-bit shift counter so that saturation is reachable.
module tb_bsr_chain_param;

  localparam int N_IN  = 4;
  localparam int N_OUT = 3;
  localparam int CNT_W = 3;

  logic             CK = 1'b0;
  logic             reset;
  logic             clockdr, shiftdr, updatedr;
  logic [1:0]       mode;
  logic             TDI;
  logic [N_IN-1:0]  pin_in;
  logic [N_IN-1:0]  core_in;
  logic [N_OUT-1:0] core_out;
  logic [N_OUT-1:0] pin_out;
  logic             TDO;
  logic [CNT_W-1:0] shift_cnt;

  int n_vec = 0;
  int n_err = 0;

  bsr_chain_param #(
    .N_IN(N_IN), .N_OUT(N_OUT), .IN_SAFE(4'b1001), .OUT_SAFE(3'b101), .CNT_W(CNT_W)
  ) dut (
    .CK(CK), .reset(reset), .clockdr(clockdr), .shiftdr(shiftdr), .updatedr(updatedr),
    .mode(mode), .TDI(TDI), .pin_in(pin_in), .core_in(core_in), .core_out(core_out),
    .pin_out(pin_out), .TDO(TDO), .shift_cnt(shift_cnt)
  );

  always #5 CK = ~CK;

  // One CK edge with the given strobes; returns 1 time unit after the edge.
  task automatic strobe(input logic cd, input logic sd, input logic ud, input logic t);
    clockdr = cd; shiftdr = sd; updatedr = ud; TDI = t;
    @(posedge CK);
    #1;
    clockdr = 1'b0; shiftdr = 1'b0; updatedr = 1'b0; TDI = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; clockdr = 1'b0; shiftdr = 1'b0; updatedr = 1'b0; TDI = 1'b0;
    mode = 2'b10; pin_in = 4'b0000; core_out = 3'b000;
    #2;
    n_vec++; if (pin_out !== 3'b101) begin n_err++; $display("FAIL reset_pin_out got %b exp %b", pin_out, 3'b101); end
    n_vec++; if (TDO !== 1'b0) begin n_err++; $display("FAIL reset_tdo got %b exp %b", TDO, 1'b0); end
    n_vec++; if (shift_cnt !== 3'd0) begin n_err++; $display("FAIL reset_cnt got %0d exp %0d", shift_cnt, 0); end
    mode = 2'b11;
    #0.5;
    n_vec++; if (core_in !== 4'b1001) begin n_err++; $display("FAIL reset_core_in got %b exp %b", core_in, 4'b1001); end
    #0.5;
    reset = 1'b0;
  endtask

  task automatic test_sample();
    logic [6:0] exp_tdo;
    exp_tdo = 7'b1110100;
    mode = 2'b01; pin_in = 4'b1010; core_out = 3'b011;
    #1;
    n_vec++; if (core_in !== 4'b1010) begin n_err++; $display("FAIL sample_core_in got %b exp %b", core_in, 4'b1010); end
    n_vec++; if (pin_out !== 3'b011) begin n_err++; $display("FAIL sample_pin_out got %b exp %b", pin_out, 3'b011); end
    strobe(1'b1, 1'b0, 1'b0, 1'b0);
    n_vec++; if (TDO !== 1'b0) begin n_err++; $display("FAIL sample_cap_tdo got %b exp %b", TDO, 1'b0); end
    for (int k = 0; k < 7; k++) begin
      strobe(1'b1, 1'b1, 1'b0, 1'b0);
      n_vec++; if (TDO !== exp_tdo[6-k]) begin n_err++; $display("FAIL sample_shift%0d_tdo got %b exp %b", k, TDO, exp_tdo[6-k]); end
    end
    n_vec++; if (shift_cnt !== 3'd7) begin n_err++; $display("FAIL sample_cnt got %0d exp %0d", shift_cnt, 7); end
    strobe(1'b1, 1'b1, 1'b0, 1'b1);
    n_vec++; if (shift_cnt !== 3'd7) begin n_err++; $display("FAIL sample_cnt_sat got %0d exp %0d", shift_cnt, 7); end
    n_vec++; if (TDO !== 1'b0) begin n_err++; $display("FAIL sample_shift8_tdo got %b exp %b", TDO, 1'b0); end
    strobe(1'b0, 1'b1, 1'b0, 1'b1);
    n_vec++; if (shift_cnt !== 3'd7) begin n_err++; $display("FAIL noclk_cnt got %0d exp %0d", shift_cnt, 7); end
    n_vec++; if (TDO !== 1'b0) begin n_err++; $display("FAIL noclk_tdo got %b exp %b", TDO, 1'b0); end
    strobe(1'b1, 1'b0, 1'b0, 1'b0);
    n_vec++; if (shift_cnt !== 3'd0) begin n_err++; $display("FAIL recap_cnt got %0d exp %0d", shift_cnt, 0); end
  endtask

  task automatic test_extest();
    logic [6:0] seq;
    seq = 7'b1100000;
    mode = 2'b10; pin_in = 4'b0101; core_out = 3'b011;
    for (int k = 0; k < 7; k++) strobe(1'b1, 1'b1, 1'b0, seq[6-k]);
    n_vec++; if (pin_out !== 3'b101) begin n_err++; $display("FAIL extest_pre_upd got %b exp %b", pin_out, 3'b101); end
    n_vec++; if (TDO !== 1'b1) begin n_err++; $display("FAIL extest_tdo got %b exp %b", TDO, 1'b1); end
    strobe(1'b0, 1'b0, 1'b1, 1'b0);
    n_vec++; if (pin_out !== 3'b110) begin n_err++; $display("FAIL extest_pin_out got %b exp %b", pin_out, 3'b110); end
    n_vec++; if (core_in !== 4'b0101) begin n_err++; $display("FAIL extest_core_in got %b exp %b", core_in, 4'b0101); end
    mode = 2'b00;
    #1;
    n_vec++; if (pin_out !== 3'b011) begin n_err++; $display("FAIL func_pin_out got %b exp %b", pin_out, 3'b011); end
    mode = 2'b10;
    #1;
    n_vec++; if (pin_out !== 3'b110) begin n_err++; $display("FAIL extest_back got %b exp %b", pin_out, 3'b110); end
  endtask

  task automatic test_intest();
    logic [6:0] seq;
    seq = 7'b0000110;
    mode = 2'b00;
    for (int k = 0; k < 7; k++) strobe(1'b1, 1'b1, 1'b0, seq[6-k]);
    strobe(1'b0, 1'b0, 1'b1, 1'b0);
    mode = 2'b11; pin_in = 4'b1001; core_out = 3'b010;
    #1;
    n_vec++; if (core_in !== 4'b0110) begin n_err++; $display("FAIL intest_core_in_a got %b exp %b", core_in, 4'b0110); end
    n_vec++; if (pin_out !== 3'b010) begin n_err++; $display("FAIL intest_pin_out got %b exp %b", pin_out, 3'b010); end
    pin_in = 4'b1111; core_out = 3'b100;
    #1;
    n_vec++; if (core_in !== 4'b0110) begin n_err++; $display("FAIL intest_core_in_b got %b exp %b", core_in, 4'b0110); end
    strobe(1'b1, 1'b0, 1'b0, 1'b0);
    n_vec++; if (TDO !== 1'b1) begin n_err++; $display("FAIL intest_cap_tdo got %b exp %b", TDO, 1'b1); end
    n_vec++; if (shift_cnt !== 3'd0) begin n_err++; $display("FAIL intest_cap_cnt got %0d exp %0d", shift_cnt, 0); end
    n_vec++; if (core_in !== 4'b0110) begin n_err++; $display("FAIL intest_hold got %b exp %b", core_in, 4'b0110); end
    strobe(1'b1, 1'b1, 1'b0, 1'b0);
    n_vec++; if (TDO !== 1'b0) begin n_err++; $display("FAIL intest_sh1_tdo got %b exp %b", TDO, 1'b0); end
  endtask

  task automatic test_back_to_back();
    logic [6:0] seq;
    seq = 7'b0000001;
    for (int k = 0; k < 7; k++) strobe(1'b1, 1'b1, 1'b0, seq[6-k]);
    strobe(1'b1, 1'b1, 1'b1, 1'b1);
    mode = 2'b11;
    #1;
    n_vec++; if (core_in !== 4'b0001) begin n_err++; $display("FAIL b2b_up_in got %b exp %b", core_in, 4'b0001); end
    mode = 2'b10;
    #1;
    n_vec++; if (pin_out !== 3'b000) begin n_err++; $display("FAIL b2b_up_out got %b exp %b", pin_out, 3'b000); end
    n_vec++; if (TDO !== 1'b0) begin n_err++; $display("FAIL b2b_tdo got %b exp %b", TDO, 1'b0); end
    for (int k = 0; k < 4; k++) strobe(1'b1, 1'b1, 1'b0, 1'b0);
    n_vec++; if (TDO !== 1'b0) begin n_err++; $display("FAIL b2b_sh4_tdo got %b exp %b", TDO, 1'b0); end
    strobe(1'b1, 1'b1, 1'b0, 1'b0);
    n_vec++; if (TDO !== 1'b1) begin n_err++; $display("FAIL b2b_sh5_tdo got %b exp %b", TDO, 1'b1); end
    strobe(1'b1, 1'b1, 1'b0, 1'b0);
    n_vec++; if (TDO !== 1'b1) begin n_err++; $display("FAIL b2b_sh6_tdo got %b exp %b", TDO, 1'b1); end
  endtask

  task automatic test_reset_mid();
    logic [6:0] exp_tdo;
    exp_tdo = 7'b0100110;
    mode = 2'b10; pin_in = 4'b1010; core_out = 3'b111;
    strobe(1'b1, 1'b0, 1'b0, 1'b0);
    n_vec++; if (TDO !== 1'b1) begin n_err++; $display("FAIL mid_cap_tdo got %b exp %b", TDO, 1'b1); end
    for (int k = 0; k < 3; k++) strobe(1'b1, 1'b1, 1'b0, 1'b1);
    #1;
    reset = 1'b1;
    #1;
    n_vec++; if (TDO !== 1'b0) begin n_err++; $display("FAIL mid_rst_tdo got %b exp %b", TDO, 1'b0); end
    n_vec++; if (shift_cnt !== 3'd0) begin n_err++; $display("FAIL mid_rst_cnt got %0d exp %0d", shift_cnt, 0); end
    n_vec++; if (pin_out !== 3'b101) begin n_err++; $display("FAIL mid_rst_pin_out got %b exp %b", pin_out, 3'b101); end
    mode = 2'b11;
    #1;
    n_vec++; if (core_in !== 4'b1001) begin n_err++; $display("FAIL mid_rst_core_in got %b exp %b", core_in, 4'b1001); end
    reset = 1'b0;
    mode = 2'b10; pin_in = 4'b0011; core_out = 3'b101;
    strobe(1'b1, 1'b0, 1'b0, 1'b0);
    n_vec++; if (TDO !== 1'b1) begin n_err++; $display("FAIL post_cap_tdo got %b exp %b", TDO, 1'b1); end
    for (int k = 0; k < 7; k++) begin
      strobe(1'b1, 1'b1, 1'b0, 1'b0);
      n_vec++; if (TDO !== exp_tdo[6-k]) begin n_err++; $display("FAIL post_shift%0d_tdo got %b exp %b", k, TDO, exp_tdo[6-k]); end
    end
    n_vec++; if (shift_cnt !== 3'd7) begin n_err++; $display("FAIL post_cnt got %0d exp %0d", shift_cnt, 7); end
    strobe(1'b0, 1'b0, 1'b1, 1'b0);
    n_vec++; if (pin_out !== 3'b000) begin n_err++; $display("FAIL post_upd_pin_out got %b exp %b", pin_out, 3'b000); end
  endtask

  initial begin
    test_reset();
    test_sample();
    test_extest();
    test_intest();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bsr_chain_param.md
Name: bsr_chain_param

Overview:
- Parametrised boundary-scan register for wrapping any core.
- Generalises the fixed per-pin scan-cell chain to `N_IN` input cells and `N_OUT` output cells.
- Adds an explicit instruction mode (FUNCTIONAL / SAMPLE_PRELOAD / EXTEST / INTEST), reset-safe update values and a shift-length counter.
- Sits between chip pins and the core; the TAP controller supplies the DR strobes; TDO feeds the TAP output mux.

Parameters:
- `N_IN`, 36, number of input boundary cells (pin -> core).
- `N_OUT`, 39, number of output boundary cells (core -> pin).
- `IN_SAFE`, all zeros, `N_IN`-bit reset value of the input update stage.
- `OUT_SAFE`, all zeros, `N_OUT`-bit reset value of the output update stage.
- `CNT_W`, 16, width of `shift_cnt`.

Ports:
- `CK` input 1: single clock; all state updates on rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `clockdr` input 1: DR clock enable; shift stage loads only when high.
- `shiftdr` input 1: when `clockdr`=1: 1 = serial shift, 0 = parallel capture.
- `updatedr` input 1: update enable; copies shift stage into update stage.
- `mode` input 2: 00 FUNCTIONAL, 01 SAMPLE_PRELOAD, 10 EXTEST, 11 INTEST.
- `TDI` input 1: serial data in.
- `pin_in` input `N_IN`: values from chip input pins.
- `core_in` output `N_IN`: values driven to core inputs.
- `core_out` input `N_OUT`: values from core outputs.
- `pin_out` output `N_OUT`: values driven to chip output pins.
- `TDO` output 1: serial data out (last shift-stage bit).
- `shift_cnt` output `CNT_W`: shift cycles since last capture, saturating.

Behaviour:
- State:
  - shift stage `sh[N_IN+N_OUT-1:0]`, update stage `up[N_IN+N_OUT-1:0]`, counter.
  - Chain order: `TDI` -> `sh[0]` (input cell 0) ... `sh[N_IN-1]` -> `sh[N_IN]` (output cell 0) ... `sh[N_IN+N_OUT-1]` -> `TDO`.
- Reset (async, immediate):
  - `sh` = 0, `up` = {`OUT_SAFE`, `IN_SAFE`}, `shift_cnt` = 0, `TDO` = 0.
  - `core_in`/`pin_out` follow the combinational mux rules below using the reset `up` values.
- Shift stage, when `clockdr`=1 at a CK edge:
  - `shiftdr`=1: `sh[0]`<=`TDI`, `sh[i]`<=`sh[i-1]`.
  - `shiftdr`=0 (capture): input cells <= `pin_in`, output cells <= `core_out`, in every mode.
  - `clockdr`=0: `sh` holds.
- `TDO` = `sh[MSB]` (registered); changes only on shift/capture/reset.
- Update stage: `updatedr`=1 at a CK edge -> `up` <= `sh` (pre-edge value); otherwise `up` holds.
- `updatedr` and `clockdr` in the same cycle: both act; `up` gets the old `sh`, `sh` gets the new shift/capture value.
- Output mux (combinational, zero latency from `mode`/`up`/pins):
  - FUNCTIONAL, SAMPLE_PRELOAD: `core_in`=`pin_in`, `pin_out`=`core_out`.
  - EXTEST: `core_in`=`pin_in`, `pin_out`=`up` output cells.
  - INTEST: `core_in`=`up` input cells, `pin_out`=`core_out`.
- Mode change takes effect in the same cycle; `sh`/`up` are untouched by mode changes.
- `shift_cnt`:
  - Clears to 0 on a capture.
  - Increments on each shift, saturating at 2^`CNT_W`-1.
  - Holds otherwise.
  - Unaffected by update.
- Strobe legality: illegal strobe combinations do not exist; `shiftdr` with `clockdr`=0 is a no-op.
- Reset asserted mid-shift: chain contents are lost; `up` returns to the safe values; after deassertion the first CK edge behaves normally.
- Degenerate sizes: `N_IN`=0 or `N_OUT`=0 is not supported; both must be >=1.

Test Plan:
- Reset with `N_IN`=4, `N_OUT`=3, `OUT_SAFE`=3'b101, `mode`=EXTEST -> `pin_out`=101, `TDO`=0, `shift_cnt`=0, all asynchronously before any CK edge.
- SAMPLE: `pin_in`=4'b1010, `core_out`=3'b011; capture 1 cycle, then shift 7 cycles with `TDI`=0.
  - Before the 1st shift `TDO` = MSB of `core_out` (0); TDO sequence across the 7 shifts = `core_out` MSB-first (remaining), then `pin_in` MSB-first.
  - `shift_cnt`=7.
- EXTEST preload: shift in 7 bits so `sh` = {3'b110, 4'b0000}, pulse `updatedr` -> `pin_out`=110 the next cycle; `core_in` still tracks `pin_in`.
- INTEST: preload input cells 4'b0110, update, `mode`=11 -> `core_in`=0110 regardless of `pin_in`; capture grabs live `core_out`.
- Simultaneous `updatedr`+`clockdr`/`shiftdr` with `sh`=0000001 (MSB 0), `TDI`=1 -> `up`=0000001, `sh`=0000011.
- Reset asserted after 3 of 7 shifts -> `sh`=0, `up`=safe, `shift_cnt`=0; a subsequent full capture/shift sequence is correct.
